tx_flit_arbiter: RTL and testbench

TX_FLIT_ARBITER -- requirements
Module: tx_flit_arbiter

---
 rtl/tx_flit_arbiter.sv | 119 +++++++++++
 tb/tb_tx_flit_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_flit_arbiter.sv
// Flit arbiter: NUM_CH input channels into one registered output slot, with
// strict-priority or round-robin selection plus a starvation override.
module tx_flit_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int FLIT_W       = 128,
    parameter int MODE         = 0,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                        nocclk,
    input  logic                        rst_n,
    input  logic [NUM_CH*FLIT_W-1:0]    in_flit,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    output logic [FLIT_W-1:0]           out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    output logic                        starve_evt
);

    localparam int         CH_W  = $clog2(NUM_CH);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]        r_starve_cnt [NUM_CH];
    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;
    logic [CH_W-1:0]   r_out_ch;

    logic [NUM_CH-1:0] w_starved;
    logic              w_forced;
    logic              w_has_win;
    logic [CH_W-1:0]   w_win_idx;
    logic              w_can_load;
    logic              w_xfer;
    logic [CH_W-1:0]   w_rr_next;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_starved[i] = in_valid[i] && (r_starve_cnt[i] >= LIMIT);
        end
    end

    // Descending scans let the lowest qualifying index overwrite the others.
    always_comb begin
        w_forced  = 1'b0;
        w_win_idx = '0;
        w_has_win = |in_valid;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_starved[i]) begin
                w_forced  = 1'b1;
                w_win_idx = CH_W'(i);
            end
        end
        if (!w_forced) begin
            if (MODE == 0) begin
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        w_win_idx = CH_W'(i);
                    end
                end
            end else begin
                for (int k = NUM_CH - 1; k >= 0; k--) begin
                    if (in_valid[(int'(r_rr_ptr) + k) % NUM_CH]) begin
                        w_win_idx = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
                    end
                end
            end
        end
    end

    // Reset gates the handshake so nothing is accepted while rst_n is low.
    assign w_can_load = !r_out_valid || out_ready;
    assign w_xfer     = rst_n && w_can_load && w_has_win;
    assign in_ready   = w_xfer ? (NUM_CH'(1) << w_win_idx) : '0;
    assign starve_evt = w_xfer && w_forced;
    assign w_rr_next  = (w_win_idx == CH_W'(NUM_CH - 1)) ? '0 : w_win_idx + CH_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_flit  <= in_flit[int'(w_win_idx)*FLIT_W +: FLIT_W];
            r_out_ch    <= w_win_idx;
            r_rr_ptr    <= w_rr_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // NOTE: this counter array is a small bank of flops, not a RAM, so it takes the asynchronous reset like any other state.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_starve_cnt[i] <= '0;
            end
        end else if (w_xfer) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_ready[i]) begin
                    r_starve_cnt[i] <= '0;
                end else if (in_valid[i] && (r_starve_cnt[i] != 8'hFF)) begin
                    r_starve_cnt[i] <= r_starve_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_tx_flit_arbiter.sv
// Bench for tx_flit_arbiter: strict-priority, round-robin and a small random
// instance, each compared cycle by cycle against a rule-level model.
module tb_tx_flit_arbiter;

    typedef struct packed {
        logic [15:0]  rdy;
        logic         sevt;
        logic         ov;
        logic [3:0]   och;
        logic [127:0] oflit;
    } obs_t;

    logic nocclk = 1'b0;
    logic rst_n;
    always #5 nocclk = ~nocclk;

    logic [511:0] sp_flit;  logic [3:0] sp_valid, sp_ready;  logic [127:0] sp_oflit;
    logic         sp_ov, sp_oready, sp_sevt;  logic [1:0] sp_och;
    logic [511:0] rr_flit;  logic [3:0] rr_valid, rr_ready;  logic [127:0] rr_oflit;
    logic         rr_ov, rr_oready, rr_sevt;  logic [1:0] rr_och;
    logic [95:0]  rd_flit;  logic [2:0] rd_valid, rd_ready;  logic [31:0] rd_oflit;
    logic         rd_ov, rd_oready, rd_sevt;  logic [1:0] rd_och;

    tx_flit_arbiter u_sp (
        .nocclk(nocclk), .rst_n(rst_n), .in_flit(sp_flit), .in_valid(sp_valid),
        .in_ready(sp_ready), .out_flit(sp_oflit), .out_valid(sp_ov),
        .out_ready(sp_oready), .out_ch(sp_och), .starve_evt(sp_sevt)
    );

    tx_flit_arbiter #(.NUM_CH(4), .FLIT_W(128), .MODE(1), .STARVE_LIMIT(16)) u_rr (
        .nocclk(nocclk), .rst_n(rst_n), .in_flit(rr_flit), .in_valid(rr_valid),
        .in_ready(rr_ready), .out_flit(rr_oflit), .out_valid(rr_ov),
        .out_ready(rr_oready), .out_ch(rr_och), .starve_evt(rr_sevt)
    );

    tx_flit_arbiter #(.NUM_CH(3), .FLIT_W(32), .MODE(0), .STARVE_LIMIT(3)) u_rd (
        .nocclk(nocclk), .rst_n(rst_n), .in_flit(rd_flit), .in_valid(rd_valid),
        .in_ready(rd_ready), .out_flit(rd_oflit), .out_valid(rd_ov),
        .out_ready(rd_oready), .out_ch(rd_och), .starve_evt(rd_sevt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state per instance (0 = strict, 1 = round robin, 2 = random).
    int           m_cnt   [3][16];
    int           m_ptr   [3];
    bit           m_ov    [3];
    int           m_och   [3];
    logic [127:0] m_oflit [3];

    function automatic int n_of(int id);     return (id == 2) ? 3 : 4;   endfunction
    function automatic int mode_of(int id);  return (id == 1) ? 1 : 0;   endfunction
    function automatic int limit_of(int id); return (id == 2) ? 3 : 16;  endfunction

    function automatic void model_reset(int id);
        for (int i = 0; i < 16; i++) m_cnt[id][i] = 0;
        m_ptr[id] = 0; m_ov[id] = 0; m_och[id] = 0; m_oflit[id] = '0;
    endfunction

    function automatic int model_pick(int id, logic [15:0] v, output bit forced);
        int n;
        n = n_of(id);
        forced = 0;
        for (int i = 0; i < n; i++)
            if (v[i] && m_cnt[id][i] >= limit_of(id)) begin forced = 1; return i; end
        if (mode_of(id) == 0) begin
            for (int i = 0; i < n; i++) if (v[i]) return i;
        end else begin
            for (int k = 0; k < n; k++) begin
                int j;
                j = (m_ptr[id] + k) % n;
                if (v[j]) return j;
            end
        end
        return -1;
    endfunction

    function automatic void model_commit(int id, logic [15:0] v, int w);
        for (int i = 0; i < n_of(id); i++) begin
            if (i == w) m_cnt[id][i] = 0;
            else if (v[i] && m_cnt[id][i] < 255) m_cnt[id][i]++;
        end
        m_ptr[id] = (w + 1) % n_of(id);
    endfunction

    function automatic logic [511:0] rnd_flits();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input int id, input logic [15:0] v, input logic ordy, input logic [511:0] f);
        case (id)
            0:       begin sp_valid = v[3:0]; sp_oready = ordy; sp_flit = f; end
            1:       begin rr_valid = v[3:0]; rr_oready = ordy; rr_flit = f; end
            default: begin rd_valid = v[2:0]; rd_oready = ordy; rd_flit = f[95:0]; end
        endcase
    endtask

    // One clock of stimulus on one instance; returns DUT observations and model predictions.
    task automatic step(input int id, input logic [15:0] v, input logic ordy, input logic [511:0] f,
                        output obs_t got, output obs_t exp);
        bit forced; bit xfer; int w; int fw; logic [127:0] sel;
        drive(id, v, ordy, f);
        #1;
        fw   = (id == 2) ? 32 : 128;
        w    = model_pick(id, v, forced);
        xfer = (!m_ov[id] || ordy) && (w >= 0);
        got  = '0;
        exp  = '0;
        if (xfer) exp.rdy = 16'(1) << w;
        exp.sevt = xfer && forced;
        case (id)
            0:       begin got.rdy = 16'(sp_ready); got.sevt = sp_sevt; end
            1:       begin got.rdy = 16'(rr_ready); got.sevt = rr_sevt; end
            default: begin got.rdy = 16'(rd_ready); got.sevt = rd_sevt; end
        endcase
        @(posedge nocclk);
        #1;
        if (xfer) begin
            sel = f[w*fw +: 128];
            m_oflit[id] = (fw == 32) ? {96'b0, sel[31:0]} : sel;
            m_ov[id]  = 1;
            m_och[id] = w;
            model_commit(id, v, w);
        end else if (ordy) begin
            m_ov[id] = 0;
        end
        exp.ov = m_ov[id]; exp.och = 4'(m_och[id]); exp.oflit = m_oflit[id];
        case (id)
            0:       begin got.ov = sp_ov; got.och = 4'(sp_och); got.oflit = sp_oflit; end
            1:       begin got.ov = rr_ov; got.och = 4'(rr_och); got.oflit = rr_oflit; end
            default: begin got.ov = rd_ov; got.och = 4'(rd_och); got.oflit = {96'b0, rd_oflit}; end
        endcase
        if (!exp.ov) begin
            exp.och = '0; exp.oflit = '0; got.och = '0; got.oflit = '0;
        end
    endtask

    task automatic idle(input int id);
        obs_t g, e;
        step(id, 16'h0, 1'b1, '0, g, e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 16'hF, 1'b1, rnd_flits());
        drive(1, 16'hF, 1'b1, rnd_flits());
        drive(2, 16'h7, 1'b1, rnd_flits());
        #13;
        checks++;
        if ({sp_ready, sp_sevt, sp_ov, sp_och, sp_oflit} !== '0) begin
            errors++;
            $display("FAIL reset_sp got rdy=%b sevt=%b ov=%b ch=%0d flit=%h want all zero", sp_ready, sp_sevt, sp_ov, sp_och, sp_oflit);
        end
        checks++;
        if ({rr_ready, rr_sevt, rr_ov, rr_och, rr_oflit} !== '0) begin
            errors++;
            $display("FAIL reset_rr got rdy=%b sevt=%b ov=%b ch=%0d flit=%h want all zero", rr_ready, rr_sevt, rr_ov, rr_och, rr_oflit);
        end
        checks++;
        if ({rd_ready, rd_sevt, rd_ov, rd_och, rd_oflit} !== '0) begin
            errors++;
            $display("FAIL reset_rd got rdy=%b sevt=%b ov=%b ch=%0d flit=%h want all zero", rd_ready, rd_sevt, rd_ov, rd_och, rd_oflit);
        end
        drive(0, 16'h0, 1'b1, '0);
        drive(1, 16'h0, 1'b1, '0);
        drive(2, 16'h0, 1'b1, '0);
        @(negedge nocclk);
        rst_n = 1'b1;
        for (int id = 0; id < 3; id++) model_reset(id);
        @(posedge nocclk);
        #1;
    endtask

    task automatic test_strict_starve();
        obs_t got, exp;
        int   och_seq [20];
        int   n_sevt, first_sevt;
        n_sevt = 0; first_sevt = -1;
        for (int c = 0; c < 20; c++) begin
            step(0, 16'b0110, 1'b1, rnd_flits(), got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL strict_cycle %0d got %h want %h", c, got, exp);
            end
            och_seq[c] = int'(got.och);
            if (got.sevt) begin
                n_sevt++;
                if (first_sevt < 0) first_sevt = c;
            end
        end
        checks++;
        if (first_sevt != 16 || n_sevt != 1) begin
            errors++;
            $display("FAIL strict_forced_slot got first=%0d count=%0d want first=16 count=1", first_sevt, n_sevt);
        end
        checks++;
        if (och_seq[0] != 1 || och_seq[15] != 1 || och_seq[16] != 2 || och_seq[17] != 1) begin
            errors++;
            $display("FAIL strict_out_ch got %0d,%0d,%0d,%0d want 1,1,2,1", och_seq[0], och_seq[15], och_seq[16], och_seq[17]);
        end
        idle(0);
    endtask

    task automatic test_round_robin();
        obs_t got, exp;
        for (int k = 0; k < 12; k++) begin
            step(1, 16'b1111, 1'b1, rnd_flits(), got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rr_cycle %0d got %h want %h", k, got, exp);
            end
            checks++;
            if (int'(got.och) != k % 4 || got.sevt !== 1'b0 || got.ov !== 1'b1) begin
                errors++;
                $display("FAIL rr_sequence %0d got ch=%0d sevt=%b ov=%b want ch=%0d sevt=0 ov=1", k, got.och, got.sevt, got.ov, k % 4);
            end
        end
        idle(1);
    endtask

    task automatic test_rr_wrap();
        obs_t got, exp;
        step(1, 16'b0100, 1'b1, rnd_flits(), got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wrap_setup got %h want %h", got, exp);
        end
        step(1, 16'b0001, 1'b1, rnd_flits(), got, exp);
        checks++;
        if (got.rdy !== 16'h1 || got.och !== 4'd0 || got.ov !== 1'b1) begin
            errors++;
            $display("FAIL wrap_grant got rdy=%h ch=%0d ov=%b want rdy=0001 ch=0 ov=1", got.rdy, got.och, got.ov);
        end
        step(1, 16'b0011, 1'b1, rnd_flits(), got, exp);
        checks++;
        if (got.rdy !== 16'h2 || got.och !== 4'd1) begin
            errors++;
            $display("FAIL wrap_ptr_after got rdy=%h ch=%0d want rdy=0002 ch=1", got.rdy, got.och);
        end
        idle(1);
    endtask

    task automatic test_backpressure();
        obs_t         got, exp;
        logic [511:0] f;
        logic [127:0] first_flit;
        int           n_xfer;
        n_xfer = 0;
        for (int c = 0; c < 5; c++) begin
            f = rnd_flits();
            if (c == 0) first_flit = f[3*128 +: 128];
            step(0, 16'b1000, 1'b0, f, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall_cycle %0d got %h want %h", c, got, exp);
            end
            if (got.rdy != 0) n_xfer++;
            checks++;
            if (got.oflit !== first_flit || got.och !== 4'd3) begin
                errors++;
                $display("FAIL stall_hold %0d got ch=%0d flit=%h want ch=3 flit=%h", c, got.och, got.oflit, first_flit);
            end
        end
        checks++;
        if (n_xfer != 1) begin
            errors++;
            $display("FAIL stall_transfers got %0d want 1", n_xfer);
        end
        f = rnd_flits();
        step(0, 16'b1000, 1'b1, f, got, exp);
        checks++;
        if (got.rdy !== 16'h8 || got.ov !== 1'b1 || got.oflit !== f[3*128 +: 128]) begin
            errors++;
            $display("FAIL stall_release got rdy=%h ov=%b flit=%h want rdy=0008 ov=1 flit=%h", got.rdy, got.ov, got.oflit, f[3*128 +: 128]);
        end
        idle(0);
    endtask

    task automatic test_reset_midstream();
        obs_t got, exp;
        int   bad_cnt;
        for (int c = 0; c < 3; c++) step(1, 16'b0110, 1'b1, rnd_flits(), got, exp);
        for (int c = 0; c < 5; c++) step(0, 16'b0110, 1'b1, rnd_flits(), got, exp);
        checks++;
        if (sp_ov !== 1'b1 || rr_ov !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got sp_ov=%b rr_ov=%b want 1 1", sp_ov, rr_ov);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sp_ov !== 1'b0 || rr_ov !== 1'b0 || sp_ready !== 4'b0 || rr_ready !== 4'b0 || sp_sevt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got sp_ov=%b rr_ov=%b sp_rdy=%b rr_rdy=%b sevt=%b want all zero", sp_ov, rr_ov, sp_ready, rr_ready, sp_sevt);
        end
        bad_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (u_sp.r_starve_cnt[i] !== 8'd0) bad_cnt++;
            if (u_rr.r_starve_cnt[i] !== 8'd0) bad_cnt++;
        end
        checks++;
        if (bad_cnt != 0) begin
            errors++;
            $display("FAIL midrst_counters got %0d nonzero counters want 0", bad_cnt);
        end
        drive(0, 16'b1100, 1'b1, rnd_flits());
        drive(1, 16'b0000, 1'b1, '0);
        drive(2, 16'b0000, 1'b1, '0);
        #2;
        rst_n = 1'b1;
        for (int id = 0; id < 3; id++) model_reset(id);
        step(0, 16'b1100, 1'b1, rnd_flits(), got, exp);
        checks++;
        if (got.rdy !== 16'h4 || got.och !== 4'd2 || got.sevt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_first_sp got rdy=%h ch=%0d sevt=%b want rdy=0004 ch=2 sevt=0", got.rdy, got.och, got.sevt);
        end
        step(1, 16'b1010, 1'b1, rnd_flits(), got, exp);
        checks++;
        if (got.rdy !== 16'h2 || got.och !== 4'd1) begin
            errors++;
            $display("FAIL midrst_first_rr got rdy=%h ch=%0d want rdy=0002 ch=1", got.rdy, got.och);
        end
        idle(0);
        idle(1);
    endtask

    task automatic test_random();
        obs_t         got, exp, prev;
        bit           pend [3];
        logic [31:0]  dat  [3];
        int           seq  [3];
        logic [31:0]  sbq  [3][$];
        logic [15:0]  v;
        logic [511:0] f;
        logic         ordy;
        logic [31:0]  want;
        int           acc, emi, ch, left;
        acc = 0; emi = 0; prev = '0;
        for (int c = 0; c < 3; c++) begin pend[c] = 0; seq[c] = 0; dat[c] = '0; end
        for (int it = 0; it < 700; it++) begin
            for (int c = 0; c < 3; c++) begin
                if (!pend[c] && it < 600 && $urandom_range(0, 1) == 1) begin
                    pend[c] = 1;
                    dat[c]  = {8'(c), 24'(seq[c])};
                end
            end
            v = '0; f = '0;
            for (int c = 0; c < 3; c++) begin v[c] = pend[c]; f[c*32 +: 32] = dat[c]; end
            ordy = (it >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(2, v, ordy, f, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_cycle %0d got %h want %h", it, got, exp);
            end
            if (prev.ov && ordy) begin
                ch = int'(prev.och);
                checks++;
                if (ch > 2 || sbq[ch].size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_flit got ch=%0d flit=%h want no output", ch, prev.oflit[31:0]);
                end else begin
                    want = sbq[ch].pop_front();
                    if (prev.oflit[31:0] !== want) begin
                        errors++;
                        $display("FAIL rand_order ch %0d got %h want %h", ch, prev.oflit[31:0], want);
                    end
                end
                emi++;
            end
            for (int c = 0; c < 3; c++) begin
                if (pend[c] && got.rdy[c]) begin
                    sbq[c].push_back(dat[c]);
                    pend[c] = 0;
                    seq[c]++;
                    acc++;
                end
            end
            prev = got;
        end
        left = 0;
        for (int c = 0; c < 3; c++) left += sbq[c].size() + int'(pend[c]);
        checks++;
        if (left != 0 || acc != emi || acc < 100) begin
            errors++;
            $display("FAIL rand_drain got left=%0d accepted=%0d emitted=%0d want left=0 equal counts >=100", left, acc, emi);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_strict_starve();
        test_round_robin();
        test_rr_wrap();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
